// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, default bus widths, reset PC.
// No logic; imported by the fetch datapath and its latency counter.
package cpu_pkg;

    localparam int CPU_DATA_WIDTH = 16;
    localparam int CPU_ADDR_WIDTH = 8;
    localparam int CPU_RESET_PC   = 0;

    // Counter is sized for the largest legal memory latency (7 -> loads 6).
    localparam int LAT_CNT_W      = $clog2(8);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_e;

    function automatic logic [LAT_CNT_W-1:0] lat_load_val(input int unsigned latency);
        return LAT_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/fetch_lat_counter.sv
// Loadable down-counter timing the wait for fixed-latency RAM read data.
// Latency: count registered, zero flag combinational from count; no backpressure.
module fetch_lat_counter
    import cpu_pkg::*;
#(
    parameter int W = LAT_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Clear beats load so a redirect always leaves the counter idle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, fixed-latency RAM read, instruction register. Optional FETCH_UNIT_PERF_EN counters.
// Latency: data captured MEM_LATENCY edges after issue, MEM_LATENCY+2 cycles per instruction.
// Backpressure: instr_valid holds until instr_ready; no new issue meanwhile; branch redirects from any state.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH  = CPU_DATA_WIDTH,
    parameter int                    ADDR_WIDTH  = CPU_ADDR_WIDTH,
    parameter int                    MEM_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(CPU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] pc
`ifdef FETCH_UNIT_PERF_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [15:0]           flush_count
`endif
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load_val(MEM_LATENCY);

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic                  r_instr_vld;

    logic                  w_issue;
    logic                  w_lat_dec;
    logic                  w_lat_zero;

    // Issue depends only on state, run and branch: instr_ready never reaches mem_rd_en.
    assign w_issue   = (r_state == S_ISSUE) && run && !branch_valid;
    assign w_lat_dec = (r_state == S_WAIT) && !w_lat_zero;

    fetch_lat_counter #(
        .W(LAT_CNT_W)
    ) u_lat_cnt (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_clear    (branch_valid),
        .i_load     (w_issue),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_lat_dec),
        .o_zero     (w_lat_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_ISSUE;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_instr_vld <= 1'b0;
        end else if (branch_valid) begin
            // Redirect wins everywhere; an in-flight read is simply never sampled.
            r_state     <= S_ISSUE;
            r_pc        <= branch_target;
            r_instr_vld <= 1'b0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_lat_zero) begin
                        r_instr     <= mem_rdata;
                        r_instr_pc  <= r_pc;
                        r_pc        <= r_pc + 1'b1;
                        r_instr_vld <= 1'b1;
                        r_state     <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        r_instr_vld <= 1'b0;
                        r_state     <= S_ISSUE;
                    end
                end
                default: begin
                    r_state     <= S_ISSUE;
                    r_instr_vld <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_en   = w_issue;
    assign mem_addr    = r_pc;
    assign pc          = r_pc;
    assign instruction = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_vld;

`ifdef FETCH_UNIT_PERF_EN
    logic        w_handshake;
    logic        w_flush;
    logic [31:0] r_fetch_cnt;
    logic [15:0] r_flush_cnt;

    // A branch coinciding with a handshake is a completed fetch, not a flush.
    assign w_handshake = r_instr_vld && instr_ready;
    assign w_flush     = branch_valid &&
                         ((r_state == S_WAIT) || (r_instr_vld && !instr_ready));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_handshake && (r_fetch_cnt != '1)) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit at memory latencies 1 (u0), 3 (u1) and 2 (u2).
// Each instance has its own fixed-latency RAM pipeline; off-cycle reads return 16'hDEAD.
module tb_fetch_unit;

    logic        clk;
    int          cyc;
    int          checks;
    int          errors;

    logic        rst_n  [3];
    logic        run_i  [3];
    logic        bv     [3];
    logic [7:0]  bt     [3];
    logic        rdy    [3];
    logic        rd_en  [3];
    logic [7:0]  addr   [3];
    logic [15:0] rdata  [3];
    logic [15:0] instr  [3];
    logic [7:0]  ipc    [3];
    logic        vld    [3];
    logic [7:0]  pcv    [3];
`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] fc     [3];
    logic [15:0] flc    [3];
`endif

    logic [15:0] ram [256];
    logic [7:0]  pa  [3][3];
    logic        pv  [3][3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .MEM_LATENCY(1), .RESET_PC(8'h00)) u0 (
        .clk(clk), .reset_n(rst_n[0]), .run(run_i[0]), .branch_valid(bv[0]), .branch_target(bt[0]),
        .mem_rd_en(rd_en[0]), .mem_addr(addr[0]), .mem_rdata(rdata[0]), .instruction(instr[0]),
        .instr_pc(ipc[0]), .instr_valid(vld[0]), .instr_ready(rdy[0]), .pc(pcv[0])
`ifdef FETCH_UNIT_PERF_EN
        , .fetch_count(fc[0]), .flush_count(flc[0])
`endif
    );

    fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .MEM_LATENCY(3), .RESET_PC(8'h00)) u1 (
        .clk(clk), .reset_n(rst_n[1]), .run(run_i[1]), .branch_valid(bv[1]), .branch_target(bt[1]),
        .mem_rd_en(rd_en[1]), .mem_addr(addr[1]), .mem_rdata(rdata[1]), .instruction(instr[1]),
        .instr_pc(ipc[1]), .instr_valid(vld[1]), .instr_ready(rdy[1]), .pc(pcv[1])
`ifdef FETCH_UNIT_PERF_EN
        , .fetch_count(fc[1]), .flush_count(flc[1])
`endif
    );

    fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .MEM_LATENCY(2), .RESET_PC(8'h00)) u2 (
        .clk(clk), .reset_n(rst_n[2]), .run(run_i[2]), .branch_valid(bv[2]), .branch_target(bt[2]),
        .mem_rd_en(rd_en[2]), .mem_addr(addr[2]), .mem_rdata(rdata[2]), .instruction(instr[2]),
        .instr_pc(ipc[2]), .instr_valid(vld[2]), .instr_ready(rdy[2]), .pc(pcv[2])
`ifdef FETCH_UNIT_PERF_EN
        , .fetch_count(fc[2]), .flush_count(flc[2])
`endif
    );

    // Stage k holds the read issued k edges ago; data is visible only in stage LATENCY-1.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            pa[i][2] <= pa[i][1];
            pa[i][1] <= pa[i][0];
            pa[i][0] <= addr[i];
            pv[i][2] <= pv[i][1];
            pv[i][1] <= pv[i][0];
            pv[i][0] <= rd_en[i];
        end
    end

    assign rdata[0] = pv[0][0] ? ram[pa[0][0]] : 16'hDEAD;
    assign rdata[1] = pv[1][2] ? ram[pa[1][2]] : 16'hDEAD;
    assign rdata[2] = pv[2][1] ? ram[pa[2][1]] : 16'hDEAD;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic wait_valid(input int i, input int maxc, output bit found);
        found = 1'b0;
        for (int n = 0; n < maxc && !found; n++) begin
            tick();
            if (vld[i]) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; run_i[i] = 1'b0; bv[i] = 1'b0; bt[i] = 8'h00; rdy[i] = 1'b0;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (vld[i] !== 1'b0) begin errors++; $display("FAIL reset_valid u%0d: got %b expected 0", i, vld[i]); end
            checks++; if (pcv[i] !== 8'h00) begin errors++; $display("FAIL reset_pc u%0d: got %h expected 00", i, pcv[i]); end
            checks++; if (instr[i] !== 16'h0000) begin errors++; $display("FAIL reset_instr u%0d: got %h expected 0000", i, instr[i]); end
            checks++; if (rd_en[i] !== 1'b0) begin errors++; $display("FAIL reset_rd_en u%0d: got %b expected 0", i, rd_en[i]); end
`ifdef FETCH_UNIT_PERF_EN
            checks++; if (fc[i] !== 32'd0) begin errors++; $display("FAIL reset_fetch_count u%0d: got %0d expected 0", i, fc[i]); end
            checks++; if (flc[i] !== 16'd0) begin errors++; $display("FAIL reset_flush_count u%0d: got %0d expected 0", i, flc[i]); end
`endif
        end
    endtask

    // Cycle offsets count from the last edge that sampled reset_n low.
    task automatic test_linear_fetch();
        logic [15:0] exp_w [3];
        int c0;
        bit found;
        exp_w[0] = 16'hA001; exp_w[1] = 16'hB002; exp_w[2] = 16'hC003;
        rst_n[0] = 1'b1; run_i[0] = 1'b1; rdy[0] = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_valid(0, 12, found);
            checks++;
            if (!found) begin
                errors++; $display("FAIL linear_timeout word%0d: got no instr_valid expected valid", k);
            end else begin
                checks++; if (instr[0] !== exp_w[k]) begin errors++; $display("FAIL linear_instr word%0d: got %h expected %h", k, instr[0], exp_w[k]); end
                checks++; if (ipc[0] !== 8'(k)) begin errors++; $display("FAIL linear_instr_pc word%0d: got %h expected %h", k, ipc[0], 8'(k)); end
                checks++; if (cyc - c0 !== 2 + 3 * k) begin errors++; $display("FAIL linear_timing word%0d: got %0d expected %0d", k, cyc - c0, 2 + 3 * k); end
            end
        end
        checks++; if (pcv[0] !== 8'h03) begin errors++; $display("FAIL linear_pc_end: got %h expected 03", pcv[0]); end
        run_i[0] = 1'b0;
        tick();
        checks++; if (vld[0] !== 1'b0 || rd_en[0] !== 1'b0) begin errors++; $display("FAIL linear_idle: got vld=%b rd_en=%b expected 0 0", vld[0], rd_en[0]); end
`ifdef FETCH_UNIT_PERF_EN
        checks++; if (fc[0] !== 32'd3) begin errors++; $display("FAIL linear_fetch_count: got %0d expected 3", fc[0]); end
`endif
    endtask

    task automatic test_latency_sweep();
        int c0;
        int t_first;
        bit found;
        rst_n[1] = 1'b1; run_i[1] = 1'b1; rdy[1] = 1'b1;
        c0 = cyc;
        wait_valid(1, 12, found);
        t_first = cyc;
        checks++; if (!found) begin errors++; $display("FAIL lat3_first_timeout: got no instr_valid expected valid"); end
        checks++; if (cyc - c0 !== 4) begin errors++; $display("FAIL lat3_first_timing: got %0d expected 4", cyc - c0); end
        checks++; if (instr[1] !== 16'hA001) begin errors++; $display("FAIL lat3_first_instr: got %h expected A001", instr[1]); end
        wait_valid(1, 12, found);
        checks++; if (!found) begin errors++; $display("FAIL lat3_second_timeout: got no instr_valid expected valid"); end
        checks++; if (cyc - t_first !== 5) begin errors++; $display("FAIL lat3_spacing: got %0d expected 5", cyc - t_first); end
        checks++; if (instr[1] !== 16'hB002 || ipc[1] !== 8'h01) begin errors++; $display("FAIL lat3_second_instr: got %h@%h expected B002@01", instr[1], ipc[1]); end
        run_i[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        bit found;
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1; run_i[0] = 1'b1; rdy[0] = 1'b0;
        wait_valid(0, 8, found);
        checks++; if (!found || instr[0] !== 16'hA001) begin errors++; $display("FAIL bp_first: got found=%b instr=%h expected 1 A001", found, instr[0]); end
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++; if (instr[0] !== 16'hA001 || vld[0] !== 1'b1) begin errors++; $display("FAIL bp_hold cyc%0d: got %h vld=%b expected A001 vld=1", n, instr[0], vld[0]); end
            checks++; if (rd_en[0] !== 1'b0) begin errors++; $display("FAIL bp_no_issue cyc%0d: got %b expected 0", n, rd_en[0]); end
        end
        rdy[0] = 1'b1;
        tick();
        checks++; if (rd_en[0] !== 1'b1 || addr[0] !== 8'h01) begin errors++; $display("FAIL bp_release_issue: got rd_en=%b addr=%h expected 1 01", rd_en[0], addr[0]); end
        checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", vld[0]); end
        rdy[0] = 1'b0;
        wait_valid(0, 8, found);
        checks++; if (!found || instr[0] !== 16'hB002 || ipc[0] !== 8'h01) begin errors++; $display("FAIL bp_next: got %h@%h expected B002@01", instr[0], ipc[0]); end
    endtask

    task automatic test_reset_mid();
        rst_n[0] = 1'b0;
        tick();
        checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", vld[0]); end
        checks++; if (pcv[0] !== 8'h00) begin errors++; $display("FAIL midreset_pc: got %h expected 00", pcv[0]); end
        checks++; if (instr[0] !== 16'h0000 || ipc[0] !== 8'h00) begin errors++; $display("FAIL midreset_instr: got %h@%h expected 0000@00", instr[0], ipc[0]); end
`ifdef FETCH_UNIT_PERF_EN
        checks++; if (fc[0] !== 32'd0 || flc[0] !== 16'd0) begin errors++; $display("FAIL midreset_counters: got %0d/%0d expected 0/0", fc[0], flc[0]); end
`endif
        run_i[0] = 1'b0;
        rst_n[0] = 1'b1;
    endtask

    task automatic test_branch_wait();
        bit found;
        rst_n[2] = 1'b1; run_i[2] = 1'b1; rdy[2] = 1'b1;
        #1;
        checks++; if (rd_en[2] !== 1'b1 || addr[2] !== 8'h00) begin errors++; $display("FAIL br_issue0: got rd_en=%b addr=%h expected 1 00", rd_en[2], addr[2]); end
        tick();
        bv[2] = 1'b1; bt[2] = 8'h40;
        tick();
        bv[2] = 1'b0;
        #1;
        checks++; if (pcv[2] !== 8'h40 || vld[2] !== 1'b0) begin errors++; $display("FAIL br_redirect: got pc=%h vld=%b expected 40 0", pcv[2], vld[2]); end
        checks++; if (rd_en[2] !== 1'b1 || addr[2] !== 8'h40) begin errors++; $display("FAIL br_reissue: got rd_en=%b addr=%h expected 1 40", rd_en[2], addr[2]); end
        wait_valid(2, 10, found);
        checks++; if (!found) begin errors++; $display("FAIL br_timeout: got no instr_valid expected valid"); end
        checks++; if (instr[2] !== 16'h1234 || ipc[2] !== 8'h40) begin errors++; $display("FAIL br_instr: got %h@%h expected 1234@40", instr[2], ipc[2]); end
        checks++; if (pcv[2] !== 8'h41) begin errors++; $display("FAIL br_pc: got %h expected 41", pcv[2]); end
`ifdef FETCH_UNIT_PERF_EN
        checks++; if (flc[2] !== 16'd1) begin errors++; $display("FAIL br_flush_count: got %0d expected 1", flc[2]); end
`endif
    endtask

    task automatic test_wrap_halt();
        bit found;
        int bad;
        bv[2] = 1'b1; bt[2] = 8'hFF;
        tick();
        checks++; if (vld[2] !== 1'b0 || pcv[2] !== 8'hFF) begin errors++; $display("FAIL wrap_branch_handshake: got vld=%b pc=%h expected 0 FF", vld[2], pcv[2]); end
        checks++; if (rd_en[2] !== 1'b0) begin errors++; $display("FAIL wrap_branch_suppress: got %b expected 0", rd_en[2]); end
        tick();
        bv[2] = 1'b0;
        #1;
        checks++; if (rd_en[2] !== 1'b1 || addr[2] !== 8'hFF) begin errors++; $display("FAIL wrap_issue: got rd_en=%b addr=%h expected 1 FF", rd_en[2], addr[2]); end
`ifdef FETCH_UNIT_PERF_EN
        checks++; if (fc[2] !== 32'd1 || flc[2] !== 16'd1) begin errors++; $display("FAIL wrap_counters: got %0d/%0d expected 1/1", fc[2], flc[2]); end
`endif
        wait_valid(2, 10, found);
        checks++; if (!found || instr[2] !== 16'h5AFF || ipc[2] !== 8'hFF) begin errors++; $display("FAIL wrap_instr: got %h@%h expected 5AFF@FF", instr[2], ipc[2]); end
        checks++; if (pcv[2] !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h expected 00", pcv[2]); end
        tick();
        checks++; if (rd_en[2] !== 1'b1 || addr[2] !== 8'h00) begin errors++; $display("FAIL halt_issue: got rd_en=%b addr=%h expected 1 00", rd_en[2], addr[2]); end
        tick();
        run_i[2] = 1'b0;
        wait_valid(2, 6, found);
        checks++; if (!found || instr[2] !== 16'hA001 || ipc[2] !== 8'h00) begin errors++; $display("FAIL halt_drain: got %h@%h expected A001@00", instr[2], ipc[2]); end
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (rd_en[2] !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_quiet: got %0d issue cycles expected 0", bad); end
        run_i[2] = 1'b1;
        #1;
        checks++; if (rd_en[2] !== 1'b1 || addr[2] !== 8'h01) begin errors++; $display("FAIL halt_resume: got rd_en=%b addr=%h expected 1 01", rd_en[2], addr[2]); end
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0;
        for (int a = 0; a < 256; a++) ram[a] = {8'h77, 8'(a)};
        ram[8'h00] = 16'hA001;
        ram[8'h01] = 16'hB002;
        ram[8'h02] = 16'hC003;
        ram[8'h40] = 16'h1234;
        ram[8'hFF] = 16'h5AFF;

        test_reset();
        test_linear_fetch();
        test_latency_sweep();
        test_backpressure();
        test_reset_mid();
        test_branch_wait();
        test_wrap_halt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
